// File: rtl/conv_stream_writer_if.sv
// Bus bundle for conv_stream_writer: layer config/status, input stream (S_*)
// and output burst stream (M_*). Optional macro: OUT_CHECKSUM_EN adds Checksum.
interface conv_stream_writer_if #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned WIDTH_BEAT_NUM  = 20,
  parameter int unsigned WIDTH_BURST_LEN = 8
);
  logic                       Start;
  logic [WIDTH_BEAT_NUM-1:0]  Beat_Num_REG;
  logic [WIDTH_BURST_LEN-1:0] Burst_Len_REG;

  logic [DATA_WIDTH-1:0]      S_Data;
  logic                       S_Valid;
  logic                       S_Ready;
  logic                       S_Last;

  logic [DATA_WIDTH-1:0]      M_Data;
  logic                       M_Valid;
  logic                       M_Ready;
  logic                       M_Last;

  logic                       Write_Complete;
  logic                       Last_Error;
`ifdef OUT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]      Checksum;
`endif

  // Writer side of the bundle
  modport slave (
    input  Start, Beat_Num_REG, Burst_Len_REG,
    input  S_Data, S_Valid, S_Last, M_Ready,
    output S_Ready, M_Data, M_Valid, M_Last,
    output Write_Complete, Last_Error
`ifdef OUT_CHECKSUM_EN
    , output Checksum
`endif
  );

  // Environment side (compute path + DMA)
  modport master (
    output Start, Beat_Num_REG, Burst_Len_REG,
    output S_Data, S_Valid, S_Last, M_Ready,
    input  S_Ready, M_Data, M_Valid, M_Last,
    input  Write_Complete, Last_Error
`ifdef OUT_CHECKSUM_EN
    , input Checksum
`endif
  );
endinterface

// File: rtl/conv_stream_writer.sv
// Repacks the compute-path output stream into fixed-length write bursts via an
// internal FWFT FIFO, checks S_Last placement and flags layer completion.
// Optional macro: OUT_CHECKSUM_EN adds an XOR checksum of all sent beats.
module conv_stream_writer #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned WIDTH_BEAT_NUM  = 20,
  parameter int unsigned WIDTH_BURST_LEN = 8
) (
  input logic                clk,
  input logic                rst,
  conv_stream_writer_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [WIDTH_BEAT_NUM-1:0]  bn_q, bn_d;
  logic [WIDTH_BURST_LEN-1:0] bl_q, bl_d;
  logic [WIDTH_BEAT_NUM-1:0]  in_cnt_q, in_cnt_d;
  logic [WIDTH_BEAT_NUM-1:0]  out_cnt_q, out_cnt_d;
  logic [WIDTH_BURST_LEN-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic                       s_ready_q, s_ready_d;
  logic                       m_valid_q, m_valid_d;
  logic                       m_last_q, m_last_d;
  logic                       wc_q, wc_d;
  logic                       err_q, err_d;
  logic [DATA_WIDTH-1:0]      mem_q [FIFO_DEPTH];
  logic                       push, pop;
`ifdef OUT_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]      csum_q, csum_d;
`endif

  // Handshakes; ready/valid are registered so neither side sees a comb path
  assign push = s_ready_q & bus.S_Valid;
  assign pop  = m_valid_q & bus.M_Ready;

  // Next-state, counters, FIFO bookkeeping and registered output values
  always_comb begin
    state_d     = state_q;
    bn_d        = bn_q;
    bl_d        = bl_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    burst_cnt_d = burst_cnt_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    err_d       = err_q;
`ifdef OUT_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      out_cnt_d = out_cnt_q + WIDTH_BEAT_NUM'(1);
      // burst wraps after every M_Last beat, including a short final burst
      if (m_last_q) begin
        burst_cnt_d = '0;
      end else begin
        burst_cnt_d = burst_cnt_q + WIDTH_BURST_LEN'(1);
      end
`ifdef OUT_CHECKSUM_EN
      csum_d = csum_q ^ bus.M_Data;
`endif
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    unique case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          bn_d        = bus.Beat_Num_REG;
          bl_d        = bus.Burst_Len_REG;
          in_cnt_d    = '0;
          out_cnt_d   = '0;
          burst_cnt_d = '0;
          err_d       = 1'b0;
`ifdef OUT_CHECKSUM_EN
          csum_d      = '0;
`endif
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (push) begin
          in_cnt_d = in_cnt_q + WIDTH_BEAT_NUM'(1);
          // S_Last must appear exactly on the final beat of the layer
          if (bus.S_Last != (in_cnt_q == bn_q - WIDTH_BEAT_NUM'(1))) begin
            err_d = 1'b1;
          end
          if (in_cnt_d == bn_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pop && (out_cnt_q == bn_q - WIDTH_BEAT_NUM'(1))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    s_ready_d = (state_d == ST_RUN) && (count_d != FULL_CNT);
    m_valid_d = (count_d != '0);
    m_last_d  = m_valid_d &&
                ((burst_cnt_d == bl_d - WIDTH_BURST_LEN'(1)) ||
                 (out_cnt_d == bn_d - WIDTH_BEAT_NUM'(1)));
    wc_d      = (state_d == ST_DONE);
  end

  // Control and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      bn_q        <= '0;
      bl_q        <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      burst_cnt_q <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      s_ready_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      wc_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bn_q        <= bn_d;
      bl_q        <= bl_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      s_ready_q   <= s_ready_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      wc_q        <= wc_d;
      err_q       <= err_d;
    end
  end

  // FIFO storage; head entry drives M_Data directly (first-word-fall-through)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= bus.S_Data;
    end
  end

`ifdef OUT_CHECKSUM_EN
  // Running XOR of every beat accepted downstream since Start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign bus.Checksum = csum_q;
`endif

  assign bus.S_Ready        = s_ready_q;
  assign bus.M_Valid        = m_valid_q;
  assign bus.M_Data         = mem_q[rd_ptr_q];
  assign bus.M_Last         = m_last_q;
  assign bus.Write_Complete = wc_q;
  assign bus.Last_Error     = err_q;
endmodule

// File: tb/tb_conv_stream_writer.sv
// Self-checking bench for conv_stream_writer: table of layer scenarios,
// hand-written reset/backpressure sequences and randomized layers.
module tb_conv_stream_writer;
  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned WBN   = 20;
  localparam int unsigned WBL   = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  conv_stream_writer_if #(.DATA_WIDTH(DW), .WIDTH_BEAT_NUM(WBN), .WIDTH_BURST_LEN(WBL)) bus ();

  conv_stream_writer #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .WIDTH_BEAT_NUM(WBN), .WIDTH_BURST_LEN(WBL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int bn;     // Beat_Num_REG
    int bl;     // Burst_Len_REG
    int lp;     // beat index carrying S_Last (-1: never)
    int pct;    // M_Ready probability in percent
    int pat;    // 1: one-hot data pattern
    int hold;   // cycles M_Ready forced low at layer start
    int exp_b;  // expected number of M_Last beats
    bit exp_e;  // expected Last_Error
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int s_acc   = 0;
  int wc_cnt  = 0;
  int wc_cyc  = 0;
  int last_pop_cyc = 0;
  logic [DW:0] m_q[$];
  logic        stall_pend = 1'b0;
  logic [DW:0] stall_val;

  task automatic check(input string nm, input logic [DW:0] act, input logic [DW:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Observe transfers half a cycle away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      if (stall_pend && bus.M_Valid)
        check("m_stable", {bus.M_Last, bus.M_Data}, stall_val);
      stall_pend = bus.M_Valid && !bus.M_Ready;
      stall_val  = {bus.M_Last, bus.M_Data};
      if (bus.S_Valid && bus.S_Ready) s_acc++;
      if (bus.M_Valid && bus.M_Ready) begin
        m_q.push_back({bus.M_Last, bus.M_Data});
        last_pop_cyc = cyc;
      end
      if (bus.Write_Complete) begin
        wc_cnt++;
        wc_cyc = cyc;
      end
    end else begin
      stall_pend = 1'b0;
    end
  end

  task automatic start_layer(input int bn, input int bl);
    @(posedge clk); #1;
    bus.Start         = 1'b1;
    bus.Beat_Num_REG  = WBN'(bn);
    bus.Burst_Len_REG = WBL'(bl);
    @(posedge clk); #1;
    bus.Start         = 1'b0;
    bus.Beat_Num_REG  = WBN'($urandom);
    bus.Burst_Len_REG = WBL'($urandom);
  endtask

  // Run one layer and compare against the reference behaviour
  task automatic run_layer(input vec_t v, input string nm);
    logic [DW-1:0] d[$];
    logic [DW-1:0] xs;
    int base, wc0, idx, prev_idx, nlast, exp_acc;
    bit sv, exp_l;
    xs = '0;
    for (int i = 0; i < v.bn + 4; i++)
      d.push_back(v.pat != 0 ? (DW'(1) << i) : {$urandom, $urandom});
    m_q.delete();
    base = s_acc;
    wc0  = wc_cnt;
    start_layer(v.bn, v.bl);
    sv = 1'b0;
    prev_idx = -1;
    for (int c = 0; c < 3000 && wc_cnt == wc0; c++) begin
      @(posedge clk); #1;
      idx = s_acc - base;
      if (!sv || idx != prev_idx) sv = (v.hold > 0) || ($urandom_range(3) != 0);
      prev_idx = idx;
      bus.S_Valid = sv;
      bus.S_Data  = (idx < d.size()) ? d[idx] : '0;
      bus.S_Last  = (idx == v.lp);
      bus.Start   = (v.hold > 0 && c == 5);
      if (v.hold > 0 && c == 5) bus.Beat_Num_REG = WBN'(3);
      bus.M_Ready = (c >= v.hold) && ($urandom_range(99) < v.pct);
      if (v.hold > 0 && c == v.hold) begin
        exp_acc = (v.bn < int'(DEPTH)) ? v.bn : int'(DEPTH);
        check({nm, "_held_acc"}, (DW+1)'(s_acc - base), (DW+1)'(exp_acc));
        bus.M_Ready = 1'b1;
        @(negedge clk);
        check({nm, "_full_pop_sready"}, (DW+1)'(bus.S_Ready), '0);
      end
    end
    if (wc_cnt == wc0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no Write_Complete expected one", nm);
    end
    bus.S_Valid = 1'b0;
    bus.S_Last  = 1'b0;
    bus.M_Ready = 1'b0;
    bus.Start   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check({nm, "_s_accepted"}, (DW+1)'(s_acc - base), (DW+1)'(v.bn));
    check({nm, "_m_beats"}, (DW+1)'(m_q.size()), (DW+1)'(v.bn));
    check({nm, "_wc_pulses"}, (DW+1)'(wc_cnt - wc0), (DW+1)'(1));
    if (wc_cnt != wc0)
      check({nm, "_wc_timing"}, (DW+1)'(wc_cyc - last_pop_cyc), (DW+1)'(1));
    check({nm, "_last_error"}, (DW+1)'(bus.Last_Error), (DW+1)'(v.exp_e));
    nlast = 0;
    for (int j = 0; j < v.bn && j < m_q.size(); j++) begin
      exp_l = ((j % v.bl) == v.bl - 1) || (j == v.bn - 1);
      check($sformatf("%s_beat%0d", nm, j), m_q[j], {exp_l, d[j]});
      if (m_q[j][DW]) nlast++;
      xs ^= d[j];
    end
    check({nm, "_bursts"}, (DW+1)'(nlast), (DW+1)'(v.exp_b));
`ifdef OUT_CHECKSUM_EN
    check({nm, "_checksum"}, (DW+1)'(bus.Checksum), (DW+1)'(xs));
`endif
  endtask

  vec_t tbl[10];
  vec_t rv;
  int   base0;

  initial begin
    tbl[0] = '{8,  4,  7,  100, 0, 0,  2, 1'b0};
    tbl[1] = '{10, 4,  9,  100, 0, 0,  3, 1'b0};
    tbl[2] = '{5,  4,  2,  100, 0, 0,  2, 1'b1};
    tbl[3] = '{20, 4,  19, 100, 0, 30, 5, 1'b0};
    tbl[4] = '{4,  2,  3,  100, 1, 0,  2, 1'b0};
    tbl[5] = '{1,  1,  0,  50,  0, 0,  1, 1'b0};
    tbl[6] = '{7,  8,  6,  60,  0, 0,  1, 1'b0};
    tbl[7] = '{33, 5,  -1, 40,  0, 0,  7, 1'b1};
    tbl[8] = '{16, 16, 15, 70,  0, 0,  1, 1'b0};
    tbl[9] = '{3,  1,  2,  30,  0, 0,  3, 1'b0};

    rst = 1'b0;
    bus.Start = 1'b0;
    bus.Beat_Num_REG = '0;
    bus.Burst_Len_REG = '0;
    bus.S_Data = '0;
    bus.S_Valid = 1'b0;
    bus.S_Last = 1'b0;
    bus.M_Ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", (DW+1)'(bus.S_Ready), '0);
    check("rst_m_valid", (DW+1)'(bus.M_Valid), '0);
    check("rst_m_last", (DW+1)'(bus.M_Last), '0);
    check("rst_wc", (DW+1)'(bus.Write_Complete), '0);
    check("rst_last_error", (DW+1)'(bus.Last_Error), '0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int t = 0; t < 10; t++)
      run_layer(tbl[t], $sformatf("tbl%0d", t));

    // Reset in the middle of a layer, then a fresh short layer
    m_q.delete();
    base0 = s_acc;
    start_layer(8, 4);
    bus.S_Valid = 1'b1;
    bus.S_Data  = DW'(0);
    for (int c = 0; c < 50 && (s_acc - base0) < 3; c++) begin
      @(posedge clk); #1;
      bus.S_Data = DW'(s_acc - base0);
    end
    check("midrst_pre_acc", (DW+1)'(s_acc - base0), (DW+1)'(3));
    check("midrst_pre_mvalid", (DW+1)'(bus.M_Valid), (DW+1)'(1));
    rst = 1'b0;
    bus.S_Valid = 1'b0;
    @(negedge clk);
    check("midrst_m_valid", (DW+1)'(bus.M_Valid), '0);
    check("midrst_s_ready", (DW+1)'(bus.S_Ready), '0);
    check("midrst_m_last", (DW+1)'(bus.M_Last), '0);
    @(posedge clk); #1;
    rst = 1'b1;
    rv = '{2, 1, 1, 80, 0, 0, 2, 1'b0};
    run_layer(rv, "post_rst");

    // Randomized layers checked against the reference rules
    for (int r = 0; r < 10; r++) begin
      rv.bn   = $urandom_range(1, 40);
      rv.bl   = $urandom_range(1, 9);
      rv.lp   = ($urandom_range(3) != 0) ? rv.bn - 1 :
                (($urandom_range(1) != 0) ? -1 : int'($urandom_range(0, rv.bn - 1)));
      rv.pct  = $urandom_range(20, 100);
      rv.pat  = 0;
      rv.hold = 0;
      rv.exp_b = (rv.bn + rv.bl - 1) / rv.bl;
      rv.exp_e = (rv.lp != rv.bn - 1);
      run_layer(rv, $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
